// File: rtl/stepper_pkg.sv
// Shared constants and types for the stepper axis controller.
// Register offsets, CTRL bit positions and the per-axis FSM states.
package stepper_pkg;

  localparam logic [7:0] CTRL_OFF    = 8'h00;
  localparam logic [7:0] STEPS_OFF   = 8'h04;
  localparam logic [7:0] HIGH_OFF    = 8'h08;
  localparam logic [7:0] LOW_OFF     = 8'h0C;
  localparam logic [7:0] STATUS_OFF  = 8'h80;
  localparam logic [7:0] DONE_OFF    = 8'h84;
  localparam logic [7:0] IRQ_EN_OFF  = 8'h88;
  localparam logic [7:0] AXIS_STRIDE = 8'h10;

  localparam int CTRL_DIR   = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_BUSY  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } axis_state_e;

endpackage

// File: rtl/stepper_axis.sv
// One STEP/DIR channel: move FSM, timers, remaining count.
// Settings only change while idle; abort returns to idle at once.
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int STEP_W    = 16,
  parameter int DIR_SETUP = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_we,
  input  logic              steps_we,
  input  logic              high_we,
  input  logic              low_we,
  input  logic [2:0]        ctrl_wd,
  input  logic [STEP_W-1:0] steps_wd,
  input  logic [CNT_W-1:0]  cnt_wd,
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic [STEP_W-1:0] remaining,
  output logic [CNT_W-1:0]  high_cyc,
  output logic [CNT_W-1:0]  low_cyc,
  output logic              done_pulse
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  axis_state_e       state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [CNT_W-1:0]  low_q, low_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              start, abort;
  logic [CNT_W-1:0]  hi_ld, lo_ld;

  assign start = ctrl_we & ctrl_wd[CTRL_START];
  assign abort = ctrl_we & ctrl_wd[CTRL_ABORT];
  assign hi_ld = (high_q == '0) ? ONE : high_q;
  assign lo_ld = (low_q == '0) ? ONE : low_q;

  assign step       = step_q;
  assign dir        = dir_q;
  assign busy       = (state_q != S_IDLE);
  assign remaining  = steps_q;
  assign high_cyc   = high_q;
  assign low_cyc    = low_q;

  // Next state: register writes when idle, timed phases while moving.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    steps_d    = steps_q;
    high_d     = high_q;
    low_d      = low_q;
    dir_d      = dir_q;
    step_d     = step_q;
    done_pulse = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_we)  dir_d   = ctrl_wd[CTRL_DIR];
        if (steps_we) steps_d = steps_wd;
        if (high_we)  high_d  = cnt_wd;
        if (low_we)   low_d   = cnt_wd;
        if (start && steps_q != '0) begin
          state_d = S_SETUP;
          timer_d = CNT_W'(DIR_SETUP);
        end
      end
      S_SETUP: begin
        if (timer_q == ONE) begin
          state_d = S_HIGH;
          step_d  = 1'b1;
          timer_d = hi_ld;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      S_HIGH: begin
        if (timer_q == ONE) begin
          state_d = S_LOW;
          step_d  = 1'b0;
          timer_d = lo_ld;
          if (steps_q != '0) steps_d = steps_q - 1'b1;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      S_LOW: begin
        if (timer_q == ONE) begin
          if (steps_q != '0) begin
            state_d = S_HIGH;
            step_d  = 1'b1;
            timer_d = hi_ld;
          end else begin
            state_d    = S_IDLE;
            done_pulse = 1'b1;
          end
        end else begin
          timer_d = timer_q - ONE;
        end
      end
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      step_d     = 1'b0;
      timer_d    = '0;
      done_pulse = 1'b0;
    end
  end

  // State and register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      steps_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      steps_q <= steps_d;
      high_q  <= high_d;
      low_q   <= low_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/stepper_axis_ctrl.sv
// APB3 front end for NUM_AXES stepper channels plus DONE/STATUS.
// STEPPER_IRQ_EN adds the IRQ_EN register and a registered irq.
module stepper_axis_ctrl
  import stepper_pkg::*;
#(
  parameter int NUM_AXES  = 2,
  parameter int CNT_W     = 16,
  parameter int STEP_W    = 16,
  parameter int DIR_SETUP = 50
) (
  input  logic                PCLK,
  input  logic                PRESERN,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [NUM_AXES-1:0] step,
  output logic [NUM_AXES-1:0] dir,
  output logic                irq
);

  logic [7:0]          addr;
  logic                wr_en;
  logic [NUM_AXES-1:0] busy;
  logic [NUM_AXES-1:0] done_p;
  logic [STEP_W-1:0]   rem_a  [NUM_AXES];
  logic [CNT_W-1:0]    high_a [NUM_AXES];
  logic [CNT_W-1:0]    low_a  [NUM_AXES];
  logic [NUM_AXES-1:0] done_q, done_d;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign addr        = {PADDR[7:2], 2'b00};
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    localparam logic [7:0] BASE = 8'(i * AXIS_STRIDE);
    logic hit;
    assign hit = wr_en && (addr[7:4] == BASE[7:4]);
    stepper_axis #(
      .CNT_W(CNT_W),
      .STEP_W(STEP_W),
      .DIR_SETUP(DIR_SETUP)
    ) u_axis (
      .clk(PCLK),
      .rst_n(PRESERN),
      .ctrl_we(hit && addr[3:0] == CTRL_OFF[3:0]),
      .steps_we(hit && addr[3:0] == STEPS_OFF[3:0]),
      .high_we(hit && addr[3:0] == HIGH_OFF[3:0]),
      .low_we(hit && addr[3:0] == LOW_OFF[3:0]),
      .ctrl_wd(PWDATA[2:0]),
      .steps_wd(PWDATA[STEP_W-1:0]),
      .cnt_wd(PWDATA[CNT_W-1:0]),
      .step(step[i]),
      .dir(dir[i]),
      .busy(busy[i]),
      .remaining(rem_a[i]),
      .high_cyc(high_a[i]),
      .low_cyc(low_a[i]),
      .done_pulse(done_p[i])
    );
  end

`ifdef STEPPER_IRQ_EN
  logic [NUM_AXES-1:0] irq_en_q, irq_en_d;
  logic                irq_q, irq_d;
`endif

  // Read mux: axis registers, then global registers.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (addr[7:4] == 4'(i)) begin
        case (addr[3:0])
          CTRL_OFF[3:0]: begin
            rdata[CTRL_DIR]  = dir[i];
            rdata[CTRL_BUSY] = busy[i];
          end
          STEPS_OFF[3:0]: rdata = 32'(rem_a[i]);
          HIGH_OFF[3:0]:  rdata = 32'(high_a[i]);
          LOW_OFF[3:0]:   rdata = 32'(low_a[i]);
          default:        rdata = '0;
        endcase
      end
    end
    if (addr == STATUS_OFF) rdata[NUM_AXES-1:0] = busy;
    if (addr == DONE_OFF)   rdata[NUM_AXES-1:0] = done_q;
`ifdef STEPPER_IRQ_EN
    if (addr == IRQ_EN_OFF) rdata[NUM_AXES-1:0] = irq_en_q;
`endif
  end

  assign PRDATA = PSEL ? rdata : '0;

  // Sticky done bits: new completions win over a W1C in the same cycle.
  always_comb begin
    done_d = done_q;
    if (wr_en && addr == DONE_OFF) done_d = done_q & ~PWDATA[NUM_AXES-1:0];
    done_d = done_d | done_p;
`ifdef STEPPER_IRQ_EN
    irq_en_d = irq_en_q;
    if (wr_en && addr == IRQ_EN_OFF) irq_en_d = PWDATA[NUM_AXES-1:0];
    irq_d = |(done_q & irq_en_q);
`endif
  end

  // Global register flops.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      done_q <= '0;
`ifdef STEPPER_IRQ_EN
      irq_en_q <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      done_q <= done_d;
`ifdef STEPPER_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

`ifdef STEPPER_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Directed plus randomized bench for stepper_axis_ctrl.
// Pulse trains are predicted arithmetically from move parameters.
module tb_stepper_axis_ctrl;
  import stepper_pkg::*;

  localparam int NA = 2;
  localparam int D  = 50;
  localparam int BIG = 1 << 30;

  logic          PCLK = 1'b0;
  logic          PRESERN = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [31:0]   PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [NA-1:0] step;
  logic [NA-1:0] dir;
  logic          irq;

  stepper_axis_ctrl #(
    .NUM_AXES(NA),
    .CNT_W(16),
    .STEP_W(16),
    .DIR_SETUP(D)
  ) dut (
    .PCLK(PCLK),
    .PRESERN(PRESERN),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR),
    .step(step),
    .dir(dir),
    .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Move model per axis: start edge, high/low widths, count, abort edge.
  int st [NA];
  int hh [NA];
  int ll [NA];
  int nn [NA];
  int stp [NA];
  bit dd [NA];
  bit on [NA];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tend(input int a);
    return D + nn[a] * (hh[a] + ll[a]);
  endfunction

  function automatic bit e_busy(input int a);
    int k;
    k = cyc - st[a];
    return on[a] && k < stp[a] && k < tend(a);
  endfunction

  function automatic bit e_step(input int a);
    int p;
    if (!e_busy(a)) return 1'b0;
    p = cyc - st[a] - D;
    if (p < 0) return 1'b0;
    return (p % (hh[a] + ll[a])) < hh[a];
  endfunction

  function automatic int e_rem(input int a, input int k);
    int c;
    c = 0;
    for (int j = 1; j <= nn[a]; j++) begin
      int kf;
      kf = D + (j - 1) * (hh[a] + ll[a]) + hh[a];
      if (kf <= k && kf < stp[a]) c++;
    end
    return nn[a] - c;
  endfunction

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1;
    PWRITE = 1'b1;
    PENABLE = 1'b0;
    PADDR = {24'h0, a};
    PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    PSEL = 1'b1;
    PWRITE = 1'b0;
    PENABLE = 1'b0;
    PADDR = {24'h0, a};
    #1;
    d = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    apb_rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic cfg(input int a, input int h, input int l, input int n);
    logic [7:0] b;
    b = 8'(a * 16);
    apb_wr(b + HIGH_OFF, 32'(h));
    apb_wr(b + LOW_OFF, 32'(l));
    apb_wr(b + STEPS_OFF, 32'(n));
    hh[a] = (h == 0) ? 1 : h;
    ll[a] = (l == 0) ? 1 : l;
    nn[a] = n;
  endtask

  task automatic go(input int a, input bit d);
    apb_wr(8'(a * 16) + CTRL_OFF, {29'h0, 1'b0, 1'b1, d});
    st[a] = cyc;
    dd[a] = d;
    on[a] = 1'b1;
    stp[a] = BIG;
  endtask

  // Check pins and STATUS every cycle until axis a reaches sample x.
  task automatic mon(input int a, input int x);
    int bad;
    logic [31:0] s;
    logic [31:0] es;
    bad = 0;
    do begin
      @(negedge PCLK);
      es = '0;
      for (int i = 0; i < NA; i++) begin
        if (step[i] !== e_step(i)) bad++;
        if (dir[i] !== dd[i]) bad++;
        es[i] = e_busy(i);
      end
`ifndef STEPPER_IRQ_EN
      if (irq !== 1'b0) bad++;
`endif
      apb_rd(STATUS_OFF, s);
      if (s !== es) bad++;
    end while (cyc - st[a] < x);
    chk("waveform", 32'(bad), 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    int t;
    int w;
    int a;
    for (int i = 0; i < NA; i++) begin
      st[i] = 0;
      hh[i] = 1;
      ll[i] = 1;
      nn[i] = 0;
      stp[i] = BIG;
      dd[i] = 1'b0;
      on[i] = 1'b0;
    end

    repeat (3) @(posedge PCLK);
    #2;
    PRESERN = 1'b1;
    @(negedge PCLK);
    for (int i = 0; i < NA; i++) begin
      rd_chk("rst_ctrl", 8'(i * 16) + CTRL_OFF, 32'h0);
      rd_chk("rst_steps", 8'(i * 16) + STEPS_OFF, 32'h0);
      rd_chk("rst_high", 8'(i * 16) + HIGH_OFF, 32'h0);
      rd_chk("rst_low", 8'(i * 16) + LOW_OFF, 32'h0);
    end
    rd_chk("rst_status", STATUS_OFF, 32'h0);
    rd_chk("rst_done", DONE_OFF, 32'h0);
    rd_chk("rst_irqen", IRQ_EN_OFF, 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Axis0: 4 pulses, 3 high / 2 low, dir=1.
    cfg(0, 3, 2, 4);
    rd_chk("high_rb", HIGH_OFF, 32'd3);
    go(0, 1'b1);
    chk("dir_latch", 32'(dir[0]), 32'h1);
    mon(0, tend(0) + 1);
    rd_chk("a0_rem", STEPS_OFF, 32'h0);
    rd_chk("a0_ctrl", CTRL_OFF, 32'h1);
    rd_chk("a0_done", DONE_OFF, 32'h1);
    apb_wr(DONE_OFF, 32'h1);
    rd_chk("a0_w1c", DONE_OFF, 32'h0);

    // Axis1: zero timings behave as one cycle each.
    cfg(1, 0, 0, 1);
    go(1, 1'b0);
    mon(1, tend(1) + 2);
    rd_chk("a1_done", DONE_OFF, 32'h2);
    apb_wr(DONE_OFF, 32'h2);
    apb_wr(8'h10 + STEPS_OFF, 32'h0);
    apb_wr(8'h10 + CTRL_OFF, 32'h2);
    rd_chk("zero_start", STATUS_OFF, 32'h0);
    mon(1, cyc - st[1] + 4);
    rd_chk("zero_done", DONE_OFF, 32'h0);

    // Abort mid-move; writes while busy are ignored.
    cfg(0, 4, 4, 10);
    go(0, 1'b0);
    mon(0, 20);
    apb_wr(STEPS_OFF, 32'd3);
    apb_wr(HIGH_OFF, 32'd9);
    apb_wr(CTRL_OFF, 32'h3);
    mon(0, 70);
    apb_wr(CTRL_OFF, 32'h4);
    stp[0] = cyc - st[0];
    mon(0, stp[0] + 3);
    rd_chk("abort_rem", STEPS_OFF, 32'(e_rem(0, stp[0])));
    rd_chk("abort_done", DONE_OFF, 32'h0);
    rd_chk("abort_high", HIGH_OFF, 32'd4);
    chk("abort_step", 32'(step[0]), 32'h0);

    // Both axes with different timings.
    cfg(0, 2, 2, 3);
    cfg(1, 5, 1, 2);
    go(0, 1'b1);
    go(1, 1'b0);
    mon(1, tend(1) + 2);
    rd_chk("dual_done", DONE_OFF, 32'h3);
    apb_wr(DONE_OFF, 32'h3);

    // Randomized single-axis moves.
    for (int r = 0; r < 5; r++) begin
      a = int'($urandom_range(0, NA - 1));
      cfg(a, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
          int'($urandom_range(1, 5)));
      go(a, 1'($urandom_range(0, 1)));
      mon(a, tend(a) + 2);
      rd_chk("rnd_rem", 8'(a * 16) + STEPS_OFF, 32'h0);
      rd_chk("rnd_done", DONE_OFF, 32'(1 << a));
      apb_wr(DONE_OFF, 32'h3);
    end

    // W1C landing on the completion edge.
    cfg(1, 1, 1, 2);
    go(1, 1'b1);
    t = tend(1);
    mon(1, t - 3);
    apb_wr(DONE_OFF, 32'h2);
    w = cyc - st[1];
    rd_chk("w1c_race", DONE_OFF, (w <= t) ? 32'h2 : 32'h0);
    apb_wr(DONE_OFF, 32'h3);

    // Unmapped accesses.
    apb_wr(8'h24, 32'hFFFF);
    rd_chk("unmapped", 8'h24, 32'h0);

`ifdef STEPPER_IRQ_EN
    apb_wr(IRQ_EN_OFF, 32'h1);
    rd_chk("irqen_rb", IRQ_EN_OFF, 32'h1);
    cfg(0, 1, 1, 1);
    go(0, 1'b0);
    t = tend(0);
    mon(0, t);
    chk("irq_lag", 32'(irq), 32'h0);
    mon(0, t + 1);
    chk("irq_set", 32'(irq), 32'h1);
    apb_wr(DONE_OFF, 32'h1);
    mon(0, cyc - st[0] + 1);
    chk("irq_clr", 32'(irq), 32'h0);
    cfg(1, 1, 1, 1);
    go(1, 1'b0);
    mon(1, tend(1) + 3);
    chk("irq_masked", 32'(irq), 32'h0);
    rd_chk("irq_done1", DONE_OFF, 32'h2);
    apb_wr(DONE_OFF, 32'h2);
`else
    apb_wr(IRQ_EN_OFF, 32'h1);
    rd_chk("irqen_off", IRQ_EN_OFF, 32'h0);
    chk("irq_off", 32'(irq), 32'h0);
`endif

    // Reset in the middle of a high phase.
    cfg(0, 6, 6, 3);
    go(0, 1'b1);
    mon(0, D + 2);
    chk("pre_rst_step", 32'(step[0]), 32'h1);
    @(posedge PCLK);
    #2;
    PRESERN = 1'b0;
    #1;
    chk("rst_mid_step", 32'(step), 32'h0);
    chk("rst_mid_dir", 32'(dir), 32'h0);
    for (int i = 0; i < NA; i++) begin
      on[i] = 1'b0;
      dd[i] = 1'b0;
    end
    @(negedge PCLK);
    PRESERN = 1'b1;
    rd_chk("rst_mid_busy", STATUS_OFF, 32'h0);
    rd_chk("rst_mid_rem", STEPS_OFF, 32'h0);
    rd_chk("rst_mid_done", DONE_OFF, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
